sha3_absorb_stream: RTL and testbench

Parametrised AXI-Stream absorb front-end for the SHA-3 core: accepts a byte-oriented message stream of configurable width, packs it into rate-sized blocks, applies SHA-3 domain padding (0x06 … 0x80) and hands complete 1600-bit blocks to the permutation through a valid/ready handshake. It replaces the fixed 16-bit receiver + pad + register chain. It supports all four SHA3 modes, per-beat byte enables, backpressure in both directions, and the extra pad block when a message ends on a block boundary.

---
 rtl/sha3_pkg.sv | 32 +++
 rtl/sha3_byte_packer.sv | 59 +++++
 rtl/sha3_absorb_stream.sv | 138 +++++++++++++
 tb/tb_sha3_absorb_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb front-end.
// Covers the mode and rate table, padding bytes, the FSM states and the block size.
package sha3_pkg;

    localparam int STATE_BITS  = 1600;
    localparam int STATE_BYTES = STATE_BITS / 8;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        MODE_SHA3_224 = 2'd0,
        MODE_SHA3_256 = 2'd1,
        MODE_SHA3_384 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } sha3_mode_e;

    // Rate in bytes, indexed by sha3_mode_e.
    localparam logic [7:0] RATE_BYTES [4] = '{8'd144, 8'd136, 8'd104, 8'd72};

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_PAD      = 2'd1,
        ST_OUT      = 2'd2,
        ST_PAD_PEND = 2'd3
    } sha3_state_e;

    function automatic logic [7:0] rate_of(input sha3_mode_e m);
        return RATE_BYTES[m];
    endfunction

endpackage

// File: rtl/sha3_byte_packer.sv
// 200-byte block buffer with a masked write at a byte offset and a pad insert.
// A synchronous clear takes priority over both.
module sha3_byte_packer
    import sha3_pkg::*;
#(
    parameter int KEEP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [7:0]              wr_off,
    input  logic [8*KEEP_WIDTH-1:0] wr_data,
    input  logic [KEEP_WIDTH-1:0]   wr_keep,
    input  logic                    pad_en,
    input  logic [7:0]              pad_off,
    input  logic [7:0]              pad_end_off,
    output logic [STATE_BITS-1:0]   data
);

    logic [7:0] buf_q [STATE_BYTES];
    logic [7:0] buf_d [STATE_BYTES];

    // Both pad bytes are OR-ed so that pad_off == pad_end_off yields 0x86.
    always_comb begin
        for (int i = 0; i < STATE_BYTES; i++) begin
            logic [7:0] b;
            b = buf_q[i];
            if (clear) begin
                b = 8'h00;
            end else begin
                for (int k = 0; k < KEEP_WIDTH; k++) begin
                    if (wr_en && wr_keep[k] && (int'(wr_off) + k == i))
                        b = wr_data[8*k +: 8];
                end
                if (pad_en && int'(pad_off) == i)
                    b = b | PAD_DOMAIN;
                if (pad_en && int'(pad_end_off) == i)
                    b = b | PAD_END;
            end
            buf_d[i] = b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STATE_BYTES; i++)
                buf_q[i] <= 8'h00;
        end else begin
            buf_q <= buf_d;
        end
    end

    always_comb begin
        for (int i = 0; i < STATE_BYTES; i++)
            data[8*i +: 8] = buf_q[i];
    end

endmodule

// File: rtl/sha3_absorb_stream.sv
// AXI-Stream absorb front-end: packs message bytes into rate-sized blocks and applies
// SHA-3 padding. Each padded 1600-bit block is handed out through a valid/ready handshake.
module sha3_absorb_stream
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [1:0]            mode,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic [STATE_BITS-1:0] block_data,
    output logic                  block_last,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready. Valid never
    // waits on ready. Ready depends only on registered state, never on the peer's valid.

    sha3_state_e state_q, state_d;
    sha3_mode_e  mode_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        msg_end_q;

    logic        first_beat;
    sha3_mode_e  mode_eff;
    logic [7:0]  rate;
    logic        beat_acc;
    logic        blk_hs;
    logic        pad_en;
    logic [7:0]  beat_bytes;
    logic [7:0]  cnt_beat;

    // The first beat of a message uses the live mode input; later beats use the latched mode.
    assign first_beat = (cnt_q == 8'd0) && !busy_q;
    assign mode_eff   = first_beat ? sha3_mode_e'(mode) : mode_q;
    assign rate       = rate_of(mode_eff);
    assign beat_acc   = s_tvalid && s_tready;
    assign blk_hs     = block_valid && block_ready;
    assign beat_bytes = s_tlast ? 8'($countones(s_tkeep)) : 8'(KEEP_WIDTH);
    assign cnt_beat   = cnt_q + beat_bytes;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            state_q <= ST_FILL;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (beat_acc) begin
                    if (s_tlast)
                        state_d = (cnt_beat == rate) ? ST_PAD_PEND : ST_PAD;
                    else if (cnt_beat == rate)
                        state_d = ST_OUT;
                end
            end
            ST_PAD:      state_d = ST_OUT;
            ST_OUT:      if (blk_hs) state_d = ST_FILL;
            ST_PAD_PEND: if (blk_hs) state_d = ST_PAD;
            default:     state_d = ST_FILL;
        endcase
    end

    always_comb begin
        s_tready    = 1'b0;
        block_valid = 1'b0;
        block_last  = 1'b0;
        pad_en      = 1'b0;
        case (state_q)
            ST_FILL:     s_tready = ARESETn;
            ST_PAD:      pad_en = 1'b1;
            ST_OUT: begin
                block_valid = 1'b1;
                block_last  = msg_end_q;
            end
            ST_PAD_PEND: block_valid = 1'b1;
            default:     s_tready = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q     <= 8'd0;
            mode_q    <= MODE_SHA3_224;
            busy_q    <= 1'b0;
            msg_end_q <= 1'b0;
        end else begin
            if (beat_acc) begin
                cnt_q  <= cnt_beat;
                busy_q <= 1'b1;
                if (first_beat)
                    mode_q <= sha3_mode_e'(mode);
            end
            if (pad_en)
                msg_end_q <= 1'b1;
            if (blk_hs) begin
                cnt_q <= 8'd0;
                if (msg_end_q) begin
                    busy_q    <= 1'b0;
                    msg_end_q <= 1'b0;
                end
            end
        end
    end

    sha3_byte_packer #(
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_packer (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .clear       (blk_hs),
        .wr_en       (beat_acc),
        .wr_off      (cnt_q),
        .wr_data     (s_tdata),
        .wr_keep     (s_tlast ? s_tkeep : {KEEP_WIDTH{1'b1}}),
        .pad_en      (pad_en),
        .pad_off     (cnt_q),
        .pad_end_off (rate - 8'd1),
        .data        (block_data)
    );

    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha3_absorb_stream.sv
// Directed bench for sha3_absorb_stream (DATA_WIDTH=64) with hand-computed padded blocks.
module tb_sha3_absorb_stream;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          s_tvalid;
    logic          s_tready;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tkeep;
    logic          s_tlast;
    logic          block_valid;
    logic          block_ready;
    logic [1599:0] block_data;
    logic          block_last;
    logic          busy;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [1599:0] exp_blk;

    always #5 clk = ~clk;

    sha3_absorb_stream #(
        .DATA_WIDTH (64)
    ) dut (
        .ACLK        (clk),
        .ARESETn     (rst_n),
        .mode        (mode),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .block_last  (block_last),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag);
        int fi;
        fi = 0;
        for (int i = 199; i >= 0; i--)
            if (block_data[8*i +: 8] !== exp_blk[8*i +: 8]) fi = i;
        total++;
        assert (block_data === exp_blk) else begin
            bad++;
            $error("FAIL %s byte=%0d observed=%0h expected=%0h", tag, fi,
                   block_data[8*fi +: 8], exp_blk[8*fi +: 8]);
        end
    endtask

    task automatic exp_set(input int i, input logic [7:0] v);
        exp_blk[8*i +: 8] = v;
    endtask

    // Message byte i carries the value seed+i.
    task automatic exp_fill(input int seed, input int start, input int n);
        for (int i = start; i < start + n; i++)
            exp_set(i, 8'(seed + i));
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        while (!got && n < 50) begin
            @(negedge clk);
            if (s_tready) got = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("beat_accept", 32'(got), 32'd1);
    endtask

    task automatic send_full(input int seed, input int start, input int nbeats);
        logic [63:0] d;
        for (int b = 0; b < nbeats; b++) begin
            for (int j = 0; j < 8; j++)
                d[8*j +: 8] = 8'(seed + start + 8*b + j);
            send_beat(d, 8'hFF, 1'b0);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!block_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(block_valid), 32'd1);
    endtask

    task automatic handshake();
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        block_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        rst_n = 1'b0; mode = 2'd0; s_tvalid = 1'b0; s_tdata = '0;
        s_tkeep = '0; s_tlast = 1'b0; block_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_valid", 32'(block_valid), 32'd0);
        chk("rst_last", 32'(block_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        exp_blk = '0;
        chk_blk("rst_data");
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("tready_after_rst", 32'(s_tready), 32'd1);
        chk("dbg_fill", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;

        // Empty message, SHA3-256
        mode = 2'd1;
        send_beat(64'h0, 8'h00, 1'b1);
        chk("empty_pad_cycle", 32'(block_valid), 32'd0);
        chk("empty_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("empty_valid_n2", 32'(block_valid), 32'd1);
        exp_blk = '0; exp_set(0, 8'h06); exp_set(135, 8'h80);
        chk_blk("empty_data");
        chk("empty_last", 32'(block_last), 32'd1);
        handshake();
        chk("empty_done_busy", 32'(busy), 32'd0);
        chk("empty_done_valid", 32'(block_valid), 32'd0);

        // "abc", SHA3-512, garbage in masked-off bytes
        mode = 2'd3;
        send_beat(64'hDEADBEEF_AA636261, 8'h07, 1'b1);
        wait_valid("abc_valid");
        exp_blk = '0;
        exp_set(0, 8'h61); exp_set(1, 8'h62); exp_set(2, 8'h63);
        exp_set(3, 8'h06); exp_set(71, 8'h80);
        chk_blk("abc_data");
        chk("abc_last", 32'(block_last), 32'd1);
        handshake();

        // 135 bytes, SHA3-256: pad bytes collide at 135 -> 0x86
        mode = 2'd1;
        send_full(1, 0, 16);
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(1 + 128 + j);
        d[63:56] = 8'hEE;
        send_beat(d, 8'h7F, 1'b1);
        wait_valid("b135_valid");
        exp_blk = '0; exp_fill(1, 0, 135); exp_set(135, 8'h86);
        chk_blk("b135_data");
        chk("b135_last", 32'(block_last), 32'd1);
        handshake();

        // 136 bytes, SHA3-256: full block then a separate pad block
        send_full(7, 0, 16);
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(7 + 128 + j);
        send_beat(d, 8'hFF, 1'b1);
        chk("pp_valid_next", 32'(block_valid), 32'd1);
        chk("pp_first_last", 32'(block_last), 32'd0);
        exp_blk = '0; exp_fill(7, 0, 136);
        chk_blk("pp_first_data");
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pp_gap", 32'(block_valid), 32'd0);
        chk("pp_gap_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("pp_pad_valid", 32'(block_valid), 32'd1);
        exp_blk = '0; exp_set(0, 8'h06); exp_set(135, 8'h80);
        chk_blk("pp_pad_data");
        chk("pp_pad_last", 32'(block_last), 32'd1);
        @(posedge clk);
        #1;
        block_ready = 1'b0;
        chk("pp_done_busy", 32'(busy), 32'd0);
        chk("pp_done_valid", 32'(block_valid), 32'd0);

        // Backpressure on a full SHA3-512 block with the next beat waiting
        mode = 2'd3;
        send_full(3, 0, 9);
        chk("bp_valid_next", 32'(block_valid), 32'd1);
        chk("bp_last", 32'(block_last), 32'd0);
        exp_blk = '0; exp_fill(3, 0, 72);
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(8'h50 + j);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = 8'hFF; s_tlast = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_tready", 32'(s_tready), 32'd0);
            chk("bp_valid", 32'(block_valid), 32'd1);
            chk_blk("bp_hold");
        end
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        block_ready = 1'b0;
        chk("bp_resume_tready", 32'(s_tready), 32'd1);
        chk("bp_resume_valid", 32'(block_valid), 32'd0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("bp_beat_taken", 32'(dbg_state), 32'd1);
        wait_valid("bp_tail_valid");
        exp_blk = '0;
        for (int j = 0; j < 8; j++) exp_set(j, 8'(8'h50 + j));
        exp_set(8, 8'h06); exp_set(71, 8'h80);
        chk_blk("bp_tail_data");
        chk("bp_tail_last", 32'(block_last), 32'd1);
        handshake();

        // Reset mid-message, then a SHA3-384 message with a mode change after beat 1
        mode = 2'd0;
        send_full(9, 0, 5);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(block_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tready", 32'(s_tready), 32'd0);
        exp_blk = '0;
        chk_blk("mid_rst_data");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mode = 2'd2;
        send_full(8'h40, 0, 1);
        mode = 2'd0;
        send_full(8'h40, 8, 12);
        chk("relatch_valid", 32'(block_valid), 32'd1);
        chk("relatch_last", 32'(block_last), 32'd0);
        exp_blk = '0; exp_fill(8'h40, 0, 104);
        chk_blk("relatch_data");
        handshake();
        send_beat(64'h0, 8'h00, 1'b1);
        wait_valid("relatch_pad_valid");
        exp_blk = '0; exp_set(0, 8'h06); exp_set(103, 8'h80);
        chk_blk("relatch_pad_data");
        chk("relatch_pad_last", 32'(block_last), 32'd1);
        handshake();
        chk("relatch_done_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
